// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    localparam logic JMP_ABS = 1'b0;
    localparam logic JMP_REL = 1'b1;

endpackage

// File: rtl/seq_cycle_ctr.sv
// Saturating cycle counter with synchronous clear, count enable and a
// terminal-count flag that is raised while the count equals TC.
module seq_cycle_ctr #(
    parameter int unsigned CW = 16,
    parameter int unsigned TC = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/prog_sequencer.sv
// Fetch sequencer and run controller: owns the program counter, jumps,
// the req/done start handshake, halt detection, stall and cycle budget.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned D         = 10,
    parameter int unsigned TW        = 8,
    parameter int unsigned HALT_ADDR = 1020,
    parameter int unsigned CW        = 16,
    parameter int unsigned MAXCYC    = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          jump_en,
    input  logic          jump_rel,
    input  logic [TW-1:0] target,
    input  logic          halt_in,
    output logic [D-1:0]  prog_ctr,
    output logic          run,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned    TC_VAL     = (MAXCYC == 0) ? 0 : MAXCYC - 1;
    localparam logic [D-1:0]   HALT_PC    = D'(HALT_ADDR);
    localparam bit             BUDGET_ON  = (MAXCYC != 0);

    seq_state_t    r_state;
    logic [D-1:0]  r_pc;
    logic          r_done;
    logic          r_timeout;

    seq_state_t    w_state_nx;
    logic [D-1:0]  w_pc_nx;
    logic          w_done_nx;
    logic          w_timeout_nx;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_tc;
    logic [CW-1:0] w_cnt;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_pc_abs;
    logic [D-1:0]  w_pc_rel;

    seq_cycle_ctr #(
        .CW (CW),
        .TC (TC_VAL)
    ) u_cycle_ctr (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Absolute operand lands in the PC's upper bits; relative is signed.
    assign w_pc_inc = r_pc + D'(1);
    assign w_pc_abs = D'(target) << (D - TW);
    assign w_pc_rel = r_pc + D'($signed(target));

    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_done_nx    = r_done;
        w_timeout_nx = r_timeout;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nx   = S_RUN;
                    w_pc_nx      = '0;
                    w_cnt_clr    = 1'b1;
                    w_timeout_nx = 1'b0;
                    w_done_nx    = 1'b0;
                end
            end
            S_RUN: begin
                w_cnt_en = 1'b1;
                if (BUDGET_ON && w_tc) begin
                    w_state_nx   = S_DONE;
                    w_done_nx    = 1'b1;
                    w_timeout_nx = 1'b1;
                end else if (stall) begin
                    w_pc_nx = r_pc;
                end else if (halt_in || (r_pc == HALT_PC)) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                end else if (jump_en) begin
                    w_pc_nx = (jump_rel == JMP_REL) ? w_pc_rel : w_pc_abs;
                end else begin
                    w_pc_nx = w_pc_inc;
                end
            end
            S_DONE: begin
                if (!req) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_done    <= w_done_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign prog_ctr  = r_pc;
    assign busy      = (r_state == S_RUN);
    assign run       = busy && !stall;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign cycle_cnt = w_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: default instance plus a MAXCYC=50 instance.
module tb_prog_sequencer;

    typedef struct packed {
        logic [9:0]  pc;
        logic        done;
        logic        busy;
        logic        to;
        logic [15:0] cnt;
    } snap_t;

    typedef struct {
        logic       req;
        logic       stall;
        logic       jen;
        logic       jrel;
        logic       halt;
        logic [7:0] tgt;
        snap_t      exp;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_b;
    logic        stall;
    logic        jump_en;
    logic        jump_rel;
    logic [7:0]  target;
    logic        halt_in;

    logic [9:0]  prog_ctr,  prog_ctr_b;
    logic        run,       run_b;
    logic        busy,      busy_b;
    logic        done,      done_b;
    logic        timeout,   timeout_b;
    logic [15:0] cycle_cnt, cycle_cnt_b;

    snap_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .stall     (stall),
        .jump_en   (jump_en),
        .jump_rel  (jump_rel),
        .target    (target),
        .halt_in   (halt_in),
        .prog_ctr  (prog_ctr),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    prog_sequencer #(
        .MAXCYC (50)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req       (req_b),
        .stall     (stall),
        .jump_en   (jump_en),
        .jump_rel  (jump_rel),
        .target    (target),
        .halt_in   (halt_in),
        .prog_ctr  (prog_ctr_b),
        .run       (run_b),
        .busy      (busy_b),
        .done      (done_b),
        .timeout   (timeout_b),
        .cycle_cnt (cycle_cnt_b)
    );

    function automatic snap_t mk(int pc, bit d, bit b, bit t, int cnt);
        snap_t s;
        s.pc   = pc[9:0];
        s.done = d;
        s.busy = b;
        s.to   = t;
        s.cnt  = cnt[15:0];
        return s;
    endfunction

    function automatic step_t st(bit rq, bit sl, bit je, bit jr, bit hl, logic [7:0] tg,
                                 int pc, bit d, bit b, bit t, int cnt);
        step_t s;
        s.req   = rq;
        s.stall = sl;
        s.jen   = je;
        s.jrel  = jr;
        s.halt  = hl;
        s.tgt   = tg;
        s.exp   = mk(pc, d, b, t, cnt);
        return s;
    endfunction

    function automatic snap_t snap_a();
        return mk(int'(prog_ctr), done, busy, timeout, int'(cycle_cnt));
    endfunction

    function automatic snap_t snap_b();
        return mk(int'(prog_ctr_b), done_b, busy_b, timeout_b, int'(cycle_cnt_b));
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("pc=%0d done=%b busy=%b to=%b cnt=%0d", s.pc, s.done, s.busy, s.to, s.cnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(step_t s, bit use_b);
        if (use_b) begin
            req_b = s.req;
            req   = 1'b0;
        end else begin
            req   = s.req;
            req_b = 1'b0;
        end
        stall    = s.stall;
        jump_en  = s.jen;
        jump_rel = s.jrel;
        halt_in  = s.halt;
        target   = s.tgt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 1'b0; req_b = 1'b0; stall = 1'b0; jump_en = 1'b0;
        jump_rel = 1'b0; halt_in = 1'b0; target = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        snap_t got, exp;
        reset = 1'b1;
        req = 1'b0; req_b = 1'b0; stall = 1'b0; jump_en = 1'b0;
        jump_rel = 1'b0; halt_in = 1'b0; target = '0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        tick();
        got = snap_a(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got %s want %s", fmt(got), fmt(exp));
        end
        checks++;
        if ({run, run_b, snap_b()} !== {1'b0, 1'b0, mk(0, 0, 0, 0, 0)}) begin
            errors++;
            $display("FAIL reset_run got run=%b run_b=%b %s want run=0 run_b=0 all zero", run, run_b, fmt(snap_b()));
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_count_to_halt();
        step_t q[$];
        snap_t got, exp;
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 1020; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, k, 0, 1, 0, k));
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 1020, 1, 0, 0, 1021));
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 1020, 1, 0, 0, 1021));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 1020, 0, 0, 0, 1021));
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            sb.push_back(q[i].exp);
            tick();
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL count_to_halt step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_jump_abs();
        step_t q[$];
        snap_t got, exp;
        for (int k = 0; k <= 3; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, k, 0, 1, 0, k));
        q.push_back(st(1, 0, 1, 0, 0, 8'hFF, 1020, 0, 1, 0, 4));
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 1020, 1, 0, 0, 5));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 1020, 0, 0, 0, 5));
        for (int k = 0; k <= 3; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, k, 0, 1, 0, k));
        q.push_back(st(1, 0, 1, 0, 0, 8'h01, 4, 0, 1, 0, 4));
        q.push_back(st(1, 0, 0, 0, 1, 8'h00, 4, 1, 0, 0, 5));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 4, 0, 0, 0, 5));
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            sb.push_back(q[i].exp);
            tick();
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL jump_abs step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_jump_rel_wrap();
        step_t q[$];
        snap_t got, exp;
        for (int k = 0; k <= 5; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, k, 0, 1, 0, k));
        q.push_back(st(1, 0, 1, 1, 0, 8'hFB, 0, 0, 1, 0, 6));
        q.push_back(st(1, 0, 1, 1, 0, 8'hFF, 1023, 0, 1, 0, 7));
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8));
        q.push_back(st(1, 0, 1, 1, 1, 8'hFF, 0, 1, 0, 0, 9));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 9));
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            sb.push_back(q[i].exp);
            tick();
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL jump_rel_wrap step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_stall();
        step_t q[$];
        snap_t got, exp;
        logic  prev_busy;
        logic  exp_run;
        for (int k = 0; k <= 7; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, k, 0, 1, 0, k));
        for (int k = 1; k <= 3; k++) q.push_back(st(1, 1, 1, 0, 1, 8'hFF, 7, 0, 1, 0, 7 + k));
        q.push_back(st(1, 0, 0, 0, 1, 8'h00, 7, 1, 0, 0, 11));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 7, 0, 0, 0, 11));
        prev_busy = 1'b0;
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            #1;
            exp_run = prev_busy && !q[i].stall;
            checks++;
            if (run !== exp_run) begin
                errors++;
                $display("FAIL stall_run step %0d got run=%b want run=%b", i, run, exp_run);
            end
            sb.push_back(q[i].exp);
            @(posedge clk);
            #1;
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
            prev_busy = exp.busy;
        end
    endtask

    task automatic test_budget();
        step_t q[$];
        snap_t got, exp;
        q.push_back(st(1, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 49; k++) q.push_back(st(1, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, k));
        q.push_back(st(1, 0, 1, 0, 1, 8'h00, 0, 1, 0, 1, 50));
        q.push_back(st(1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 50));
        q.push_back(st(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 50));
        q.push_back(st(1, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        foreach (q[i]) begin
            drive(q[i], 1'b1);
            sb.push_back(q[i].exp);
            tick();
            got = snap_b(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL budget step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
        do_reset();
    endtask

    task automatic test_reset_midrun();
        step_t q[$];
        snap_t got, exp;
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        q.push_back(st(1, 0, 1, 0, 0, 8'h4B, 300, 0, 1, 0, 1));
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            sb.push_back(q[i].exp);
            tick();
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_midrun step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
        reset = 1'b1;
        req   = 1'b0;
        jump_en = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        #1;
        got = snap_a(); exp = sb.pop_front(); checks++;
        if ({got, run} !== {exp, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got %s run=%b want %s run=0", fmt(got), run, fmt(exp));
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_done_hold_restart();
        step_t q[$];
        snap_t got, exp;
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        q.push_back(st(1, 0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1));
        for (int k = 0; k < 5; k++) q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1));
        q.push_back(st(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 1));
        q.push_back(st(0, 0, 0, 0, 0, 8'h00, 2, 0, 1, 0, 2));
        foreach (q[i]) begin
            drive(q[i], 1'b0);
            sb.push_back(q[i].exp);
            tick();
            got = snap_a(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL done_hold_restart step %0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_to_halt();
        test_jump_abs();
        test_jump_rel_wrap();
        test_stall();
        test_budget();
        test_reset_midrun();
        test_done_hold_restart();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
